// File: rtl/drm_fifo_ctrl.sv
// FIFO controller for one simple-dual-port DRM (1-cycle registered-address read).
// Owns pointers/occupancy and a 2-entry prefetch buffer giving FWFT output at 1 word/clk.
module drm_fifo_ctrl #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  ram_rst
);

  localparam logic [ADDR_WIDTH:0] RAM_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic                  run;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  inflight;
  logic [1:0]            ob_cnt;
  logic [DATA_WIDTH-1:0] ob_head;
  logic [DATA_WIDTH-1:0] ob_tail;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            ob_claim;
  logic [1:0]            ob_rem;

  // run keeps s_ready low until the first clock edge after reset release
  assign s_ready     = run & ~flush & (ram_cnt < RAM_DEPTH);
  assign push        = s_valid & s_ready;
  assign m_valid     = (ob_cnt != 2'd0);
  assign m_data      = ob_head;
  assign pop         = m_valid & m_ready;

  // OB slots already spoken for (held + landing) once this cycle's pop is taken out
  assign ob_claim    = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue       = (ram_cnt != '0) & (ob_claim < 3'd2) & ~flush;
  assign ob_rem      = ob_cnt - {1'b0, pop};

  assign ram_wr_en   = push;
  assign ram_wr_addr = wptr;
  assign ram_wr_data = s_data;
  assign ram_rd_addr = rptr;
  assign ram_rst     = ~rst_n;

  assign count = {1'b0, ram_cnt} + (ADDR_WIDTH+2)'(inflight) + (ADDR_WIDTH+2)'(ob_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      ob_cnt   <= 2'd0;
    end else begin
      run <= 1'b1;
      if (flush) begin
        wptr     <= '0;
        rptr     <= '0;
        ram_cnt  <= '0;
        inflight <= 1'b0;
        ob_cnt   <= 2'd0;
      end else begin
        wptr     <= wptr + ADDR_WIDTH'(push);
        rptr     <= rptr + ADDR_WIDTH'(issue);
        ram_cnt  <= ram_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
        inflight <= issue;
        ob_cnt   <= ob_rem + {1'b0, inflight};
      end
    end
  end

  // Landing word goes to the first free slot after the pop; issue throttling keeps ob_rem <= 1 here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_head <= '0;
      ob_tail <= '0;
    end else if (flush) begin
      ob_head <= '0;
      ob_tail <= '0;
    end else begin
      if (pop && ob_cnt == 2'd2) ob_head <= ob_tail;
      if (inflight) begin
        if (ob_rem == 2'd0) ob_head <= ram_rd_data;
        else                ob_tail <= ram_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_drm_fifo_ctrl.sv
// Directed bench for drm_fifo_ctrl with a behavioural 20x256 DRM attached to the ram_* ports.
`timescale 1ns/1ps
module tb_drm_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        s_valid;
  logic        s_ready;
  logic [19:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [19:0] m_data;
  logic [9:0]  count;
  logic        ram_wr_en;
  logic [7:0]  ram_wr_addr;
  logic [19:0] ram_wr_data;
  logic [7:0]  ram_rd_addr;
  logic [19:0] ram_rd_data;
  logic        ram_rst;

  int checks = 0;
  int failures = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  drm_fifo_ctrl #(.DATA_WIDTH(20), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .ram_rst(ram_rst)
  );

  // behavioural DRM: registered read address, unregistered data out
  logic [19:0] mem [0:255];
  logic [7:0]  rd_q;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rst) rd_q <= 8'd0;
    else         rd_q <= ram_rd_addr;
  end
  assign ram_rd_data = mem[rd_q];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    tick(); tick();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%0h exp=0", s_ready); end
    checks++; if (count !== 10'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (ram_rst !== 1'b1) begin failures++; $display("FAIL rst_ram_rst got=%0h exp=1", ram_rst); end
    rst_n = 1'b1;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_release_s_ready got=%0h exp=0", s_ready); end
    tick();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_first_clk_s_ready got=%0h exp=1", s_ready); end
    // traffic, then reset mid-cycle
    s_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_data = 20'(i);
      tick();
    end
    s_data = 20'h4;
    tick(); tick();
    checks++; if (m_data !== 20'h1 || m_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_traffic got=%0h/%0h exp=1/1", m_valid, m_data); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b0 || ram_wr_en !== 1'b0) begin failures++; $display("FAIL rst_async_write got=%0h/%0h exp=0/0", s_ready, ram_wr_en); end
    checks++; if (m_valid !== 1'b0 || m_data !== 20'h0) begin failures++; $display("FAIL rst_async_read got=%0h/%0h exp=0/0", m_valid, m_data); end
    checks++; if (count !== 10'd0 || ram_rd_addr !== 8'd0) begin failures++; $display("FAIL rst_async_count got=%0d/%0h exp=0/0", count, ram_rd_addr); end
    checks++; if (ram_rst !== 1'b1) begin failures++; $display("FAIL rst_async_ram_rst got=%0h exp=1", ram_rst); end
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (s_ready !== 1'b1 || count !== 10'd0 || ram_rst !== 1'b0) begin failures++; $display("FAIL rst_after_release got=%0h/%0d/%0h exp=1/0/0", s_ready, count, ram_rst); end
  endtask

  task automatic test_single_push();
    s_valid = 1'b1; s_data = 20'hABCDE;
    tick();
    s_valid = 1'b0;
    checks++; if (count !== 10'd1 || m_valid !== 1'b0) begin failures++; $display("FAIL single_n got=%0d/%0h exp=1/0", count, m_valid); end
    tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_n1_m_valid got=%0h exp=0", m_valid); end
    tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 20'hABCDE) begin failures++; $display("FAIL single_n2_out got=%0h/%0h exp=1/abcde", m_valid, m_data); end
    checks++; if (count !== 10'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++; if (count !== 10'd0 || m_valid !== 1'b0 || m_data !== 20'hABCDE) begin failures++; $display("FAIL single_empty_hold got=%0d/%0h/%0h exp=0/0/abcde", count, m_valid, m_data); end
  endtask

  task automatic test_full();
    int acc;
    logic [19:0] w;
    acc = 0;
    exp_q.delete();
    s_valid = 1'b1; m_ready = 1'b0; s_data = 20'h100;
    for (int c = 0; c < 300; c++) begin
      if (s_ready) begin
        exp_q.push_back(s_data);
        acc++;
      end
      tick();
      s_data = 20'h100 + 20'(acc);
    end
    checks++; if (acc != 258) begin failures++; $display("FAIL full_accepted got=%0d exp=258", acc); end
    checks++; if (s_ready !== 1'b0 || count !== 10'd258) begin failures++; $display("FAIL full_state got=%0h/%0d exp=0/258", s_ready, count); end
    checks++; if (m_data !== 20'h100) begin failures++; $display("FAIL full_head got=%0h exp=100", m_data); end
    // one pop reopens s_ready on the following cycle
    w = exp_q.pop_front();
    m_ready = 1'b1;
    checks++; if (m_data !== w) begin failures++; $display("FAIL full_pop_word got=%0h exp=%0h", m_data, w); end
    tick();
    m_ready = 1'b0;
    checks++; if (s_ready !== 1'b1 || count !== 10'd257) begin failures++; $display("FAIL full_reopen got=%0h/%0d exp=1/257", s_ready, count); end
    exp_q.push_back(s_data);
    acc++;
    tick();
    s_data = 20'h100 + 20'(acc);
    checks++; if (s_ready !== 1'b0 || count !== 10'd258) begin failures++; $display("FAIL full_refill got=%0h/%0d exp=0/258", s_ready, count); end
  endtask

  task automatic test_full_push_pop();
    logic [19:0] w;
    int waited;
    w = exp_q.pop_front();
    m_ready = 1'b1; s_valid = 1'b1; s_data = 20'h7F7F7;
    checks++; if (m_data !== w) begin failures++; $display("FAIL pp_oldest got=%0h exp=%0h", m_data, w); end
    tick();
    m_ready = 1'b0;
    if (s_ready) exp_q.push_back(s_data);
    tick();
    s_valid = 1'b0;
    checks++; if (count !== 10'd258) begin failures++; $display("FAIL pp_count got=%0d exp=258", count); end
    m_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 600) begin
      if (m_valid) begin
        w = exp_q.pop_front();
        checks++; if (m_data !== w) begin failures++; $display("FAIL drain_word got=%0h exp=%0h", m_data, w); end
      end
      tick();
      waited++;
    end
    m_ready = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL drain_timeout got=%0d exp=0", exp_q.size()); end
    checks++; if (count !== 10'd0 || m_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0d/%0h exp=0/0", count, m_valid); end
  endtask

  task automatic test_stream();
    int nin, nout, first, gaps, c;
    nin = 0; nout = 0; first = -1; gaps = 0;
    m_ready = 1'b1;
    for (c = 0; c < 1300 && nout < 1000; c++) begin
      s_valid = (nin < 1000);
      s_data  = 20'(nin);
      if (m_valid) begin
        if (first < 0) first = c;
        checks++; if (m_data !== 20'(nout)) begin failures++; $display("FAIL stream_word got=%0h exp=%0h", m_data, nout); end
        nout++;
      end else if (nout > 0) begin
        gaps++;
      end
      if (s_valid && s_ready) nin++;
      tick();
    end
    s_valid = 1'b0; m_ready = 1'b0;
    checks++; if (nout != 1000) begin failures++; $display("FAIL stream_total got=%0d exp=1000", nout); end
    checks++; if (first != 3) begin failures++; $display("FAIL stream_fill got=%0d exp=3", first); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL stream_gaps got=%0d exp=0", gaps); end
    checks++; if (count !== 10'd0) begin failures++; $display("FAIL stream_count got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    int stale, waited;
    s_valid = 1'b1; s_data = 20'h11111;
    tick();
    s_valid = 1'b0;
    tick();
    checks++; if (count !== 10'd1) begin failures++; $display("FAIL flush_pre_count got=%0d exp=1", count); end
    flush = 1'b1; s_valid = 1'b1; s_data = 20'h22222;
    #1;
    checks++; if (s_ready !== 1'b0 || ram_wr_en !== 1'b0) begin failures++; $display("FAIL flush_block got=%0h/%0h exp=0/0", s_ready, ram_wr_en); end
    tick();
    flush = 1'b0; s_valid = 1'b0;
    checks++; if (count !== 10'd0 || m_valid !== 1'b0) begin failures++; $display("FAIL flush_clear got=%0d/%0h exp=0/0", count, m_valid); end
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      if (m_valid) stale++;
      tick();
    end
    checks++; if (stale != 0) begin failures++; $display("FAIL flush_stale got=%0d exp=0", stale); end
    s_valid = 1'b1; s_data = 20'h12345;
    tick();
    s_valid = 1'b0;
    waited = 0;
    while (!m_valid && waited < 10) begin
      tick();
      waited++;
    end
    checks++; if (m_valid !== 1'b1 || m_data !== 20'h12345) begin failures++; $display("FAIL flush_first got=%0h/%0h exp=1/12345", m_valid, m_data); end
    checks++; if (count !== 10'd1) begin failures++; $display("FAIL flush_count got=%0d exp=1", count); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_full();
    test_full_push_pop();
    test_stream();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
